axi_b_resp_router: RTL



---
 rtl/axi_xbar_pkg.sv | 16 +
 rtl/b_rr_arb.sv | 43 ++++
 rtl/axi_b_resp_router.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/axi_xbar_pkg.sv
// Shared AXI crossbar definitions: BRESP codes and a width helper that stays
// legal (>= 1 bit) for single-entry ranges.
package axi_xbar_pkg;

  typedef logic [1:0] bresp_t;

  localparam bresp_t RESP_OKAY   = 2'b00;
  localparam bresp_t RESP_EXOKAY = 2'b01;
  localparam bresp_t RESP_SLVERR = 2'b10;
  localparam bresp_t RESP_DECERR = 2'b11;

  function automatic int safe_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/b_rr_arb.sv
// Round-robin arbiter: search starts at the stored pointer; the pointer moves
// past the winner only on a grant, which the caller treats as accepted.
module b_rr_arb
  import axi_xbar_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_gnt
);

  localparam int PTR_W = safe_w(NUM_REQ);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_hit;

  function automatic int wrap(input int a);
    return (a >= NUM_REQ) ? a - NUM_REQ : a;
  endfunction

  always_comb begin
    o_gnt     = '0;
    w_ptr_nxt = r_ptr;
    w_hit     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_hit && i_en && i_req[wrap(int'(r_ptr) + k)]) begin
        w_hit                         = 1'b1;
        o_gnt[wrap(int'(r_ptr) + k)]  = 1'b1;
        w_ptr_nxt = PTR_W'(wrap(wrap(int'(r_ptr) + k) + 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_ptr <= '0;
    else if (w_hit) r_ptr <= w_ptr_nxt;
  end

endmodule

// File: rtl/axi_b_resp_router.sv
// B-channel router: steers downstream beats to upstream ports by BID index
// field, with per-upstream RR arbitration and a 2-entry skid buffer.
// Optional macro B_ERR_CNT_EN adds per-upstream SLVERR/DECERR pop counters.
module axi_b_resp_router
  import axi_xbar_pkg::*;
#(
  parameter int NUM_DN = 3,
  parameter int NUM_UP = 3,
  parameter int ID_W   = 4,
  parameter int IDX_W  = 2,
  parameter int CNT_W  = 8,
  localparam int BID_W  = IDX_W + ID_W,
  localparam int PORT_W = safe_w(NUM_DN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_DN*BID_W-1:0]  dn_b_bid,
  input  logic [NUM_DN*2-1:0]      dn_b_bresp,
  input  logic [NUM_DN-1:0]        dn_b_valid,
  output logic [NUM_DN-1:0]        dn_b_ready,
  output logic [NUM_UP*ID_W-1:0]   up_b_bid,
  output logic [NUM_UP*2-1:0]      up_b_bresp,
  output logic [NUM_UP-1:0]        up_b_valid,
  input  logic [NUM_UP-1:0]        up_b_ready,
  output logic                     misroute_valid,
  output logic [PORT_W-1:0]        misroute_port,
  output logic [BID_W-1:0]         misroute_bid,
  output logic [CNT_W-1:0]         misroute_cnt
`ifdef B_ERR_CNT_EN
  ,
  output logic [NUM_UP*CNT_W-1:0]  up_err_cnt
`endif
);

  typedef struct packed {
    logic [ID_W-1:0] id;
    bresp_t          resp;
  } b_pl_t;

  logic [NUM_DN-1:0][IDX_W-1:0] w_idx;
  b_pl_t [NUM_DN-1:0]           w_pl;
  logic [NUM_DN-1:0]            w_mis;
  logic [NUM_UP-1:0][NUM_DN-1:0] w_req;
  logic [NUM_UP-1:0][NUM_DN-1:0] w_gnt;
  logic [NUM_DN-1:0]            w_dn_gnt;

  always_comb begin
    w_idx = '0;
    w_pl  = '0;
    w_mis = '0;
    for (int d = 0; d < NUM_DN; d++) begin
      w_idx[d]      = dn_b_bid[d*BID_W+ID_W +: IDX_W];
      w_pl[d].id    = dn_b_bid[d*BID_W +: ID_W];
      w_pl[d].resp  = dn_b_bresp[d*2 +: 2];
      w_mis[d]      = dn_b_valid[d] & ({1'b0, w_idx[d]} >= (IDX_W+1)'(NUM_UP));
    end
  end

  always_comb begin
    w_req = '0;
    for (int u = 0; u < NUM_UP; u++)
      for (int d = 0; d < NUM_DN; d++)
        w_req[u][d] = dn_b_valid[d] & (w_idx[d] == IDX_W'(u));
  end

  // A downstream port decodes to one upstream, so OR-ing grants never collides.
  always_comb begin
    w_dn_gnt = '0;
    for (int u = 0; u < NUM_UP; u++) w_dn_gnt = w_dn_gnt | w_gnt[u];
  end

  assign dn_b_ready = {NUM_DN{rst_n}} & (w_dn_gnt | w_mis);

  for (genvar u = 0; u < NUM_UP; u++) begin : g_up
    logic [1:0] r_cnt;
    logic       r_rd;
    logic       r_wr;
    b_pl_t      r_mem [2];
    b_pl_t      w_din;
    logic       w_push;
    logic       w_pop;

    b_rr_arb #(.NUM_REQ(NUM_DN)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (w_req[u]),
      .i_en  (r_cnt != 2'd2),
      .o_gnt (w_gnt[u])
    );

    always_comb begin
      w_din = '0;
      for (int d = 0; d < NUM_DN; d++)
        if (w_gnt[u][d]) w_din = w_pl[d];
    end

    assign w_push = |w_gnt[u];
    assign w_pop  = (r_cnt != 2'd0) & up_b_ready[u];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= 2'd0;
        r_rd  <= 1'b0;
        r_wr  <= 1'b0;
      end else begin
        if (w_push) r_wr <= ~r_wr;
        if (w_pop)  r_rd <= ~r_rd;
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + 2'd1;
          2'b01:   r_cnt <= r_cnt - 2'd1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    // Payload storage needs no reset: r_cnt gates everything visible.
    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= w_din;
    end

    assign up_b_valid[u]            = (r_cnt != 2'd0);
    assign up_b_bid[u*ID_W +: ID_W] = r_mem[r_rd].id;
    assign up_b_bresp[u*2 +: 2]     = r_mem[r_rd].resp;

`ifdef B_ERR_CNT_EN
    logic [CNT_W-1:0] r_err;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        r_err <= '0;
      else if (w_pop && (r_mem[r_rd].resp == RESP_SLVERR || r_mem[r_rd].resp == RESP_DECERR)
               && r_err != '1)
        r_err <= r_err + 1'b1;
    end
    assign up_err_cnt[u*CNT_W +: CNT_W] = r_err;
`endif
  end

  logic [PORT_W-1:0] w_mis_sel;
  logic [BID_W-1:0]  w_mis_bid;
  logic [CNT_W:0]    w_mis_n;
  logic [CNT_W:0]    w_cnt_sum;
  logic              r_mis_vld;
  logic [PORT_W-1:0] r_mis_port;
  logic [BID_W-1:0]  r_mis_bid;
  logic [CNT_W-1:0]  r_mis_cnt;

  // Scan high-to-low so the lowest misrouting port wins the report.
  always_comb begin
    w_mis_sel = '0;
    w_mis_bid = '0;
    w_mis_n   = '0;
    for (int d = NUM_DN - 1; d >= 0; d--) begin
      if (w_mis[d]) begin
        w_mis_sel = PORT_W'(d);
        w_mis_bid = dn_b_bid[d*BID_W +: BID_W];
      end
    end
    for (int d = 0; d < NUM_DN; d++) w_mis_n = w_mis_n + (CNT_W+1)'(w_mis[d]);
    w_cnt_sum = {1'b0, r_mis_cnt} + w_mis_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mis_vld  <= 1'b0;
      r_mis_port <= '0;
      r_mis_bid  <= '0;
      r_mis_cnt  <= '0;
    end else begin
      r_mis_vld <= |w_mis;
      if (|w_mis) begin
        r_mis_port <= w_mis_sel;
        r_mis_bid  <= w_mis_bid;
        r_mis_cnt  <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
      end
    end
  end

  assign misroute_valid = r_mis_vld;
  assign misroute_port  = r_mis_port;
  assign misroute_bid   = r_mis_bid;
  assign misroute_cnt   = r_mis_cnt;

endmodule
